special_reg_bank: RTL and testbench

Parametrised special-purpose register bank for the Single Cycle Computer, successor to the fixed 8 x 32-bit special register file. It holds the zero register, the general spares, the stack pointer (SP), the link register (LR), the program counter (PC) and the status register (CPSR). It adds hardware PC advance, branch-and-link capture, bounded SP push/pop with sticky fault flags, masked NZCV flag updates, multiple user read ports and write-error reporting. It sits beside the general register file and feeds the fetch, ALU and load/store paths.

---
 rtl/special_reg_bank_if.sv | 24 ++
 rtl/special_reg_bank.sv | 139 +++++++++++++
 tb/tb_special_reg_bank.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/special_reg_bank_if.sv
// User register-access bus of the special register bank: one write port,
// NRD packed read ports, and the rejected-write error pulse.
interface special_reg_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NRD    = 2
);
  logic                    usr_wr_en;
  logic [ADDR_W-1:0]       usr_wr_addr;
  logic [DATA_W-1:0]       usr_wr_data;
  logic [NRD*ADDR_W-1:0]   usr_rd_addr;
  logic [NRD*DATA_W-1:0]   usr_rd_data;
  logic                    wr_err;

  modport master (
    output usr_wr_en, usr_wr_addr, usr_wr_data, usr_rd_addr,
    input  usr_rd_data, wr_err
  );

  modport slave (
    input  usr_wr_en, usr_wr_addr, usr_wr_data, usr_rd_addr,
    output usr_rd_data, wr_err
  );
endinterface

// File: rtl/special_reg_bank.sv
// Special-purpose register bank: ZR, spares, SP, LR, PC and CPSR with
// hardware PC advance, link capture, bounded push/pop and masked flag updates.
module special_reg_bank #(
  parameter int              DATA_W    = 32,
  parameter int              NREGS     = 8,
  parameter int              ADDR_W    = $clog2(NREGS),
  parameter int              NRD       = 2,
  parameter int              PC_STEP   = 4,
  parameter logic [DATA_W-1:0] SP_TOP    = DATA_W'('h1000),
  parameter logic [DATA_W-1:0] SP_BOTTOM = DATA_W'('h0800)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_inc,
  input  logic               pc_wr,
  input  logic [DATA_W-1:0]  pc_wr_data,
  input  logic               lr_capture,
  input  logic [1:0]         sp_op,
  input  logic               flags_wr,
  input  logic [3:0]         flags_mask,
  input  logic [3:0]         flags_in,
  input  logic               fault_clr,
  special_reg_bank_if.slave  usr,
  output logic [DATA_W-1:0]  re_sp,
  output logic [DATA_W-1:0]  re_lr,
  output logic [DATA_W-1:0]  re_pc,
  output logic [DATA_W-1:0]  re_cpsr,
  output logic [1:0]         sp_fault
);

  localparam logic [ADDR_W-1:0] IDX_ZR   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] IDX_SP   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] IDX_LR   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] IDX_PC   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] IDX_CPSR = ADDR_W'(7);
  localparam logic [DATA_W-1:0] STEP_C   = DATA_W'(PC_STEP);
  localparam logic [DATA_W-1:0] WORD_C   = DATA_W'(DATA_W / 8);

  logic [DATA_W-1:0] regs_r     [NREGS];
  logic [DATA_W-1:0] regs_nxt_s [NREGS];
  logic              wr_err_r;
  logic              wr_err_nxt_s;
  logic [1:0]        fault_set_s;
  logic [1:0]        fault_nxt_s;
  logic              uw_s;
  logic [DATA_W-1:0] cpsr_s;
  logic [3:0]        fmask_s;

  // Next-state selection with per-register priority resolved in one edge
  always_comb begin
    regs_nxt_s   = regs_r;
    fault_set_s  = 2'b00;
    uw_s         = usr.usr_wr_en && (usr.usr_wr_addr != IDX_ZR);
    wr_err_nxt_s = usr.usr_wr_en && (usr.usr_wr_addr == IDX_ZR);

    if (uw_s) begin
      regs_nxt_s[usr.usr_wr_addr] = usr.usr_wr_data;
    end else begin
      regs_nxt_s[IDX_ZR] = {DATA_W{1'b0}};
    end

    if (pc_wr) begin
      regs_nxt_s[IDX_PC] = pc_wr_data;
    end else if (uw_s && (usr.usr_wr_addr == IDX_PC)) begin
      regs_nxt_s[IDX_PC] = usr.usr_wr_data;
    end else if (pc_inc) begin
      regs_nxt_s[IDX_PC] = regs_r[IDX_PC] + STEP_C;
    end else begin
      regs_nxt_s[IDX_PC] = regs_r[IDX_PC];
    end

    // Link capture always sees the pre-edge PC
    if (uw_s && (usr.usr_wr_addr == IDX_LR)) begin
      regs_nxt_s[IDX_LR] = usr.usr_wr_data;
    end else if (lr_capture) begin
      regs_nxt_s[IDX_LR] = regs_r[IDX_PC] + STEP_C;
    end else begin
      regs_nxt_s[IDX_LR] = regs_r[IDX_LR];
    end

    if (uw_s && (usr.usr_wr_addr == IDX_SP)) begin
      regs_nxt_s[IDX_SP] = usr.usr_wr_data;
    end else begin
      case (sp_op)
        2'b01: begin
          if (regs_r[IDX_SP] == SP_BOTTOM) begin
            regs_nxt_s[IDX_SP] = regs_r[IDX_SP];
            fault_set_s[0]     = 1'b1;
          end else begin
            regs_nxt_s[IDX_SP] = regs_r[IDX_SP] - WORD_C;
          end
        end
        2'b10: begin
          if (regs_r[IDX_SP] == SP_TOP) begin
            regs_nxt_s[IDX_SP] = regs_r[IDX_SP];
            fault_set_s[1]     = 1'b1;
          end else begin
            regs_nxt_s[IDX_SP] = regs_r[IDX_SP] + WORD_C;
          end
        end
        default: regs_nxt_s[IDX_SP] = regs_r[IDX_SP];
      endcase
    end

    // Flag update lands on top of whatever the user write produced
    cpsr_s  = (uw_s && (usr.usr_wr_addr == IDX_CPSR)) ? usr.usr_wr_data : regs_r[IDX_CPSR];
    fmask_s = flags_wr ? flags_mask : 4'b0000;
    cpsr_s[DATA_W-1 -: 4] = (cpsr_s[DATA_W-1 -: 4] & ~fmask_s) | (flags_in & fmask_s);
    regs_nxt_s[IDX_CPSR] = cpsr_s;

    fault_nxt_s = (fault_clr ? 2'b00 : sp_fault) | fault_set_s;
  end

  // Register state, fault flags and write-error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= (i == int'(IDX_SP)) ? SP_TOP : {DATA_W{1'b0}};
      end
      sp_fault <= 2'b00;
      wr_err_r <= 1'b0;
    end else begin
      regs_r   <= regs_nxt_s;
      sp_fault <= fault_nxt_s;
      wr_err_r <= wr_err_nxt_s;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    assign usr.usr_rd_data[k*DATA_W +: DATA_W] = regs_r[usr.usr_rd_addr[k*ADDR_W +: ADDR_W]];
  end

  assign usr.wr_err = wr_err_r;
  assign re_sp      = regs_r[IDX_SP];
  assign re_lr      = regs_r[IDX_LR];
  assign re_pc      = regs_r[IDX_PC];
  assign re_cpsr    = regs_r[IDX_CPSR];

endmodule

// File: tb/tb_special_reg_bank.sv
// Directed self-checking bench for special_reg_bank with hand-computed expectations.
module tb_special_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_inc, pc_wr, lr_capture, flags_wr, fault_clr;
  logic [31:0] pc_wr_data;
  logic [1:0]  sp_op;
  logic [3:0]  flags_mask, flags_in;
  logic [31:0] re_sp, re_lr, re_pc, re_cpsr;
  logic [1:0]  sp_fault;

  int n_checks = 0;
  int n_fail   = 0;

  special_reg_bank_if #(.DATA_W(32), .ADDR_W(3), .NRD(2)) bus ();

  special_reg_bank #(
    .DATA_W(32), .NREGS(8), .NRD(2), .PC_STEP(4),
    .SP_TOP(32'h0000_1000), .SP_BOTTOM(32'h0000_0800)
  ) dut (
    .clk(clk), .reset(reset),
    .pc_inc(pc_inc), .pc_wr(pc_wr), .pc_wr_data(pc_wr_data),
    .lr_capture(lr_capture), .sp_op(sp_op),
    .flags_wr(flags_wr), .flags_mask(flags_mask), .flags_in(flags_in),
    .fault_clr(fault_clr), .usr(bus),
    .re_sp(re_sp), .re_lr(re_lr), .re_pc(re_pc), .re_cpsr(re_cpsr),
    .sp_fault(sp_fault)
  );

  always #5 clk = ~clk;

  wire [31:0] rd0 = bus.usr_rd_data[31:0];
  wire [31:0] rd1 = bus.usr_rd_data[63:32];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic user_write(input logic [2:0] addr, input logic [31:0] data);
    bus.usr_wr_en   = 1'b1;
    bus.usr_wr_addr = addr;
    bus.usr_wr_data = data;
  endtask

  task automatic idle_inputs();
    pc_inc = 1'b0; pc_wr = 1'b0; lr_capture = 1'b0; flags_wr = 1'b0; fault_clr = 1'b0;
    sp_op = 2'b00; flags_mask = 4'b0000; flags_in = 4'b0000; pc_wr_data = 32'h0;
    bus.usr_wr_en = 1'b0; bus.usr_wr_addr = 3'd0; bus.usr_wr_data = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.usr_rd_addr = {3'd3, 3'd0};
    #12;
    reset = 1'b0;
    #1;
    check_val("rst_sp", re_sp, 32'h1000);
    check_val("rst_pc", re_pc, 32'h0);
    check_val("rst_lr", re_lr, 32'h0);
    check_val("rst_cpsr", re_cpsr, 32'h0);
    check_val("rst_fault", {30'd0, sp_fault}, 32'h0);
    check_val("rst_wr_err", {31'd0, bus.wr_err}, 32'h0);
    check_val("rst_rd1_idx3", rd1, 32'h0);

    pc_inc = 1'b1;
    repeat (3) tick();
    pc_inc = 1'b0;
    check_val("pc_inc3", re_pc, 32'd12);

    pc_wr = 1'b1; pc_wr_data = 32'h20;
    tick();
    check_val("pc_wr_20", re_pc, 32'h20);
    pc_wr_data = 32'h100; pc_inc = 1'b1; lr_capture = 1'b1;
    tick();
    idle_inputs();
    check_val("branch_pc", re_pc, 32'h100);
    check_val("branch_lr", re_lr, 32'h24);

    user_write(3'd6, 32'h300); pc_inc = 1'b1;
    tick();
    user_write(3'd5, 32'h77); lr_capture = 1'b1; pc_inc = 1'b0;
    check_val("uw_pc_beats_inc", re_pc, 32'h300);
    tick();
    idle_inputs();
    check_val("uw_lr_beats_cap", re_lr, 32'h77);

    sp_op = 2'b10;
    tick();
    check_val("pop_at_top_sp", re_sp, 32'h1000);
    check_val("pop_at_top_fault", {30'd0, sp_fault}, 32'h2);
    sp_op = 2'b01;
    tick();
    check_val("push1_sp", re_sp, 32'hFFC);
    repeat (512) tick();
    sp_op = 2'b00;
    check_val("push513_sp", re_sp, 32'h800);
    check_val("push513_fault", {30'd0, sp_fault}, 32'h3);
    fault_clr = 1'b1; sp_op = 2'b01;
    tick();
    check_val("clr_vs_set_fault", {30'd0, sp_fault}, 32'h1);
    check_val("clr_vs_set_sp", re_sp, 32'h800);
    sp_op = 2'b00;
    tick();
    fault_clr = 1'b0;
    check_val("fault_cleared", {30'd0, sp_fault}, 32'h0);

    user_write(3'd4, 32'h2000); sp_op = 2'b01;
    tick();
    bus.usr_wr_en = 1'b0; sp_op = 2'b10;
    check_val("uw_sp_beats_push", re_sp, 32'h2000);
    tick();
    sp_op = 2'b00;
    check_val("pop_above_top", re_sp, 32'h2004);
    check_val("pop_above_top_fault", {30'd0, sp_fault}, 32'h0);

    user_write(3'd7, 32'hFFFF_FFFF); flags_wr = 1'b1; flags_mask = 4'b1010; flags_in = 4'b0000;
    tick();
    idle_inputs();
    check_val("cpsr_masked", re_cpsr, 32'h5FFF_FFFF);
    flags_wr = 1'b1; flags_mask = 4'b0101; flags_in = 4'b1111;
    tick();
    idle_inputs();
    check_val("cpsr_flags_only", re_cpsr, 32'h5FFF_FFFF);
    flags_wr = 1'b1; flags_mask = 4'b1100; flags_in = 4'b1000;
    tick();
    idle_inputs();
    check_val("cpsr_nz", re_cpsr, 32'h9FFF_FFFF);

    bus.usr_rd_addr = {3'd0, 3'd0};
    user_write(3'd0, 32'hDEAD);
    tick();
    bus.usr_wr_en = 1'b0;
    check_val("zr_rd0", rd0, 32'h0);
    check_val("zr_rd1", rd1, 32'h0);
    check_val("wr_err_hi", {31'd0, bus.wr_err}, 32'h1);
    tick();
    check_val("wr_err_lo", {31'd0, bus.wr_err}, 32'h0);

    bus.usr_rd_addr = {3'd7, 3'd3};
    user_write(3'd3, 32'h55);
    #1;
    check_val("rd_old_same_cycle", rd0, 32'h0);
    tick();
    bus.usr_wr_en = 1'b0;
    check_val("rd_new_after_edge", rd0, 32'h55);
    check_val("rd1_cpsr", rd1, 32'h9FFF_FFFF);

    #2;
    reset = 1'b1;
    #1;
    check_val("async_rst_idx3", rd0, 32'h0);
    check_val("async_rst_sp", re_sp, 32'h1000);
    check_val("async_rst_cpsr", re_cpsr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check_val("first_edge_after_rst", re_pc, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
